// File: rtl/l2_flush_engine_pkg.sv
// -----------------------------------------------------------------------------
// l2_flush_engine_pkg
//
// Shared definitions for the L2 flush sequencer:
//   * coherence state encodings stored in the L2 tag/state array
//   * request-out message encodings used to release lines to the directory
//   * the flush FSM state type
//   * helpers that decide whether a line is flushed and which message it uses
// -----------------------------------------------------------------------------
package l2_flush_engine_pkg;

    // Line coherence states as held in the tag/state array.
    localparam logic [1:0] ST_INVALID   = 2'd0;
    localparam logic [1:0] ST_SHARED    = 2'd1;
    localparam logic [1:0] ST_EXCLUSIVE = 2'd2;
    localparam logic [1:0] ST_MODIFIED  = 2'd3;

    // Request-out messages. PUTM carries dirty data, PUTS/PUTE are clean releases.
    localparam logic [1:0] REQ_PUTS = 2'd0;
    localparam logic [1:0] REQ_PUTE = 2'd1;
    localparam logic [1:0] REQ_PUTM = 2'd2;

    // Flush modes.
    localparam logic MODE_WRITEBACK = 1'b0;
    localparam logic MODE_FULL      = 1'b1;

    // Flush walk FSM states.
    typedef enum logic [2:0] {
        FL_IDLE     = 3'd0,
        FL_READ     = 3'd1,
        FL_CHECK    = 3'd2,
        FL_SEND_REQ = 3'd3,
        FL_SEND_INV = 3'd4,
        FL_WRITE    = 3'd5,
        FL_DONE     = 3'd6
    } flush_state_e;

    // A line takes part in the flush when it is dirty, or, in full mode,
    // whenever it holds any valid copy at all.
    function automatic logic line_selected(input logic [1:0] line_state,
                                           input logic       flush_mode);
        logic sel;
        sel = 1'b0;
        if (line_state == ST_MODIFIED) begin
            sel = 1'b1;
        end else if ((flush_mode == MODE_FULL) && (line_state != ST_INVALID)) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

    // Release message matching the state the line is being given up from.
    // INVALID never reaches this path; it maps to PUTS only to keep the
    // decode total.
    function automatic logic [1:0] coh_msg_for_state(input logic [1:0] line_state);
        logic [1:0] msg;
        case (line_state)
            ST_SHARED:    msg = REQ_PUTS;
            ST_EXCLUSIVE: msg = REQ_PUTE;
            ST_MODIFIED:  msg = REQ_PUTM;
            default:      msg = REQ_PUTS;
        endcase
        return msg;
    endfunction

endpackage

// File: rtl/l2_flush_engine.sv
// -----------------------------------------------------------------------------
// l2_flush_engine
//
// L2 flush sequencer sitting between the flush request port and the L2
// tag/state array. After accepting a flush it walks every (set, way) in
// order, way innermost. Each line chosen by the flush mode is released to the
// directory on the request-out channel, invalidated in the private L1 and then
// marked INVALID in the array. A one-cycle flush_done_o pulse ends the walk.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_valid_i/ready_o   flush request handshake (ready only when idle
//                           and no L2 transactions are outstanding)
//   flush_mode_i            0 = writeback MODIFIED lines, 1 = all valid lines
//   mshr_empty_i            no outstanding L2 transactions
//   rd_en_o/set_o/way_o     array read request, data returns next cycle
//   rd_state_i/tag_i/line_i array read data
//   wr_en_o/set_o/way_o     array state write (always to INVALID)
//   wr_state_o
//   req_out_*               release message {msg, {tag,set}, data}
//   inval_*                 L1 invalidation of line address {tag,set}
//   busy_o                  walk in progress
//   flush_done_o            one-cycle pulse at the end of a walk
// -----------------------------------------------------------------------------
module l2_flush_engine
    import l2_flush_engine_pkg::*;
#(
    parameter  int unsigned SETS        = 256,
    parameter  int unsigned WAYS        = 8,
    parameter  int unsigned ADDR_BITS   = 32,
    parameter  int unsigned OFFSET_BITS = 4,
    parameter  int unsigned LINE_BITS   = 128,
    localparam int unsigned SET_BITS    = $clog2(SETS),
    localparam int unsigned WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned TAG_BITS    = ADDR_BITS - SET_BITS - OFFSET_BITS,
    localparam int unsigned LADDR_BITS  = ADDR_BITS - OFFSET_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  flush_valid_i,
    output logic                  flush_ready_o,
    input  logic                  flush_mode_i,
    input  logic                  mshr_empty_i,

    output logic                  rd_en_o,
    output logic [SET_BITS-1:0]   rd_set_o,
    output logic [WAY_BITS-1:0]   rd_way_o,
    input  logic [1:0]            rd_state_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    input  logic [LINE_BITS-1:0]  rd_line_i,

    output logic                  wr_en_o,
    output logic [SET_BITS-1:0]   wr_set_o,
    output logic [WAY_BITS-1:0]   wr_way_o,
    output logic [1:0]            wr_state_o,

    output logic                  req_out_valid_o,
    input  logic                  req_out_ready_i,
    output logic [1:0]            req_out_coh_msg_o,
    output logic [LADDR_BITS-1:0] req_out_addr_o,
    output logic [LINE_BITS-1:0]  req_out_line_o,

    output logic                  inval_valid_o,
    input  logic                  inval_ready_i,
    output logic [LADDR_BITS-1:0] inval_addr_o,

    output logic                  busy_o,
    output logic                  flush_done_o
);

    localparam logic [SET_BITS-1:0] SET_ZERO = {SET_BITS{1'b0}};
    localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);
    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_ZERO = {WAY_BITS{1'b0}};
    localparam logic [WAY_BITS-1:0] WAY_ONE  = WAY_BITS'(1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

    // FSM and walk position
    flush_state_e          state_q, state_d;
    logic [SET_BITS-1:0]   set_q, set_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic                  mode_q, mode_d;

    // Payload of the line currently being released; held while valid is up
    logic [1:0]            msg_q, msg_d;
    logic [LADDR_BITS-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0]  line_q, line_d;

    // Registered output strobes
    logic                  rd_en_q;
    logic                  wr_en_q;
    logic                  req_valid_q;
    logic                  inval_valid_q;
    logic                  busy_q;
    logic                  done_q;

    // Combinational helpers
    logic                  accept_s;
    logic                  last_s;
    logic [SET_BITS-1:0]   set_inc_s;
    logic [WAY_BITS-1:0]   way_inc_s;

    // Walk position helpers: last-index detect and the next (set, way).
    // Way is the inner loop; the walk ends at the last index instead of
    // wrapping, so the increment is never applied past it.
    always_comb begin
        last_s    = (set_q == SET_LAST) && (way_q == WAY_LAST);
        set_inc_s = set_q;
        way_inc_s = way_q;
        if (way_q == WAY_LAST) begin
            way_inc_s = WAY_ZERO;
            set_inc_s = set_q + SET_ONE;
        end else begin
            way_inc_s = way_q + WAY_ONE;
            set_inc_s = set_q;
        end
    end

    // A flush can only be taken while idle with the MSHRs drained; a request
    // arriving at any other time is simply not acknowledged.
    always_comb begin
        flush_ready_o = (state_q == FL_IDLE) && mshr_empty_i;
        accept_s      = flush_valid_i && flush_ready_o;
    end

    // Next-state, walk position and payload capture.
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        mode_d  = mode_q;
        msg_d   = msg_q;
        addr_d  = addr_q;
        line_d  = line_q;

        case (state_q)
            FL_IDLE: begin
                if (accept_s) begin
                    mode_d  = flush_mode_i;
                    set_d   = SET_ZERO;
                    way_d   = WAY_ZERO;
                    state_d = FL_READ;
                end else begin
                    state_d = FL_IDLE;
                end
            end

            FL_READ: begin
                state_d = FL_CHECK;
            end

            // Array data for the index read last cycle is on rd_*_i now.
            // Only selected lines are captured so the payload registers stay
            // quiet while skipping clean or invalid lines.
            FL_CHECK: begin
                if (line_selected(rd_state_i, mode_q)) begin
                    msg_d   = coh_msg_for_state(rd_state_i);
                    addr_d  = {rd_tag_i, set_q};
                    line_d  = rd_line_i;
                    state_d = FL_SEND_REQ;
                end else if (last_s) begin
                    state_d = FL_DONE;
                end else begin
                    set_d   = set_inc_s;
                    way_d   = way_inc_s;
                    state_d = FL_READ;
                end
            end

            FL_SEND_REQ: begin
                if (req_out_ready_i) begin
                    state_d = FL_SEND_INV;
                end else begin
                    state_d = FL_SEND_REQ;
                end
            end

            FL_SEND_INV: begin
                if (inval_ready_i) begin
                    state_d = FL_WRITE;
                end else begin
                    state_d = FL_SEND_INV;
                end
            end

            FL_WRITE: begin
                if (last_s) begin
                    state_d = FL_DONE;
                end else begin
                    set_d   = set_inc_s;
                    way_d   = way_inc_s;
                    state_d = FL_READ;
                end
            end

            FL_DONE: begin
                state_d = FL_IDLE;
            end

            default: begin
                state_d = FL_IDLE;
            end
        endcase
    end

    // State, payload and output strobe registers. Strobes are decoded from
    // the next state so each one is high for exactly the cycles its state is
    // occupied, while still coming straight out of a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FL_IDLE;
            set_q         <= SET_ZERO;
            way_q         <= WAY_ZERO;
            mode_q        <= MODE_WRITEBACK;
            msg_q         <= 2'd0;
            addr_q        <= {LADDR_BITS{1'b0}};
            line_q        <= {LINE_BITS{1'b0}};
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            inval_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            set_q         <= set_d;
            way_q         <= way_d;
            mode_q        <= mode_d;
            msg_q         <= msg_d;
            addr_q        <= addr_d;
            line_q        <= line_d;
            rd_en_q       <= (state_d == FL_READ);
            wr_en_q       <= (state_d == FL_WRITE);
            req_valid_q   <= (state_d == FL_SEND_REQ);
            inval_valid_q <= (state_d == FL_SEND_INV);
            busy_q        <= (state_d != FL_IDLE);
            done_q        <= (state_d == FL_DONE);
        end
    end

    // Output mapping. The read and write index are both the walk position;
    // they only matter while the matching enable is high.
    always_comb begin
        rd_en_o           = rd_en_q;
        rd_set_o          = set_q;
        rd_way_o          = way_q;
        wr_en_o           = wr_en_q;
        wr_set_o          = set_q;
        wr_way_o          = way_q;
        wr_state_o        = ST_INVALID;
        req_out_valid_o   = req_valid_q;
        req_out_coh_msg_o = msg_q;
        req_out_addr_o    = addr_q;
        req_out_line_o    = line_q;
        inval_valid_o     = inval_valid_q;
        inval_addr_o      = addr_q;
        busy_o            = busy_q;
        flush_done_o      = done_q;
    end

endmodule
